// File: rtl/turbo_pkg.sv
// Shared turbo-encoder definitions: FSM states, RSC tap constants and frame defaults.
// Tap vectors are ordered {D1, D2, D3}; the shift register keeps s[0] = D1 .. s[2] = D3.
package turbo_pkg;

   localparam int unsigned DEF_FRAME_LEN = 64;
   localparam int unsigned TAIL_LEN      = 3;

   // Feedback 1 + D^2 + D^3 (13 octal) and feedforward 1 + D + D^3 (15 octal), D1..D3 taps
   localparam logic [2:0] G0_FB = 3'b011;
   localparam logic [2:0] G1_FF = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StEncode,
      StTail,
      StFin
   } rsc_state_e;

   // Reorder the shift register {s2, s1, s0} into tap order {D1, D2, D3}
   function automatic logic [2:0] tap_order(input logic [2:0] s);
      return {s[0], s[1], s[2]};
   endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// One combinational trellis step of the RSC constituent code.
// Shared by both constituent encoders of the turbo path.
module rsc_trellis_step
   import turbo_pkg::*;
(
   input  logic       u_i,
   input  logic [2:0] s_i,
   output logic       a_o,
   output logic       parity_o,
   output logic [2:0] next_s_o
);

   logic [2:0] taps;

   assign taps     = tap_order(s_i);
   assign a_o      = u_i ^ (^(G0_FB & taps));
   assign parity_o = a_o ^ (^(G1_FF & taps));
   assign next_s_o = {s_i[1], s_i[0], a_o};

endmodule

// File: rtl/rsc_frame_encoder.sv
// Frame-level RSC constituent encoder: serial info bits in, registered systematic/parity out.
// Optional trellis termination (3 tail outputs driving the state to zero) is built when
// RSC_TAIL_BITS_EN is defined; otherwise the frame ends unterminated straight after the data.
module rsc_frame_encoder
   import turbo_pkg::*;
#(
   parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
   parameter int unsigned CNT_W     = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic in_valid,
   input  logic in_bit,
   output logic in_ready,
   output logic sys_out,
   output logic par_out,
   output logic out_valid,
   output logic tail_flag,
   output logic out_frame_en,
   output logic done
);

   localparam logic [CNT_W-1:0] LastBit  = CNT_W'(FRAME_LEN - 1);
`ifdef RSC_TAIL_BITS_EN
   localparam logic [CNT_W-1:0] LastTail = CNT_W'(TAIL_LEN - 1);
`endif

   rsc_state_e       state_q, state_d;
   logic [2:0]       s_q, s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sys_q, sys_d;
   logic             par_q, par_d;
   logic             valid_q, valid_d;
   logic             tail_q, tail_d;
   logic             frame_en_q, frame_en_d;
   logic             done_q, done_d;

   logic             step_u;
   logic             step_a;
   logic             step_par;
   logic [2:0]       step_ns;
   logic             unused_step_a;

   // Termination input cancels the feedback so the register shifts in zeros
   assign step_u = (state_q == StTail) ? (s_q[1] ^ s_q[2]) : in_bit;

   rsc_trellis_step u_step (
      .u_i      (step_u),
      .s_i      (s_q),
      .a_o      (step_a),
      .parity_o (step_par),
      .next_s_o (step_ns)
   );

   // Feedback node is only consumed through next_s
   assign unused_step_a = step_a;

   // Next-state, trellis update and registered-output decode
   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      cnt_d      = cnt_q;
      sys_d      = 1'b0;
      par_d      = 1'b0;
      valid_d    = 1'b0;
      tail_d     = 1'b0;
      frame_en_d = frame_en_q;
      done_d     = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StEncode;
               s_d        = '0;
               cnt_d      = '0;
               frame_en_d = 1'b0;
            end
         end
         StEncode: begin
            if (in_valid) begin
               s_d        = step_ns;
               sys_d      = in_bit;
               par_d      = step_par;
               valid_d    = 1'b1;
               frame_en_d = 1'b1;
               if (cnt_q == LastBit) begin
                  cnt_d = '0;
`ifdef RSC_TAIL_BITS_EN
                  state_d = StTail;
`else
                  state_d = StFin;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
`ifdef RSC_TAIL_BITS_EN
         StTail: begin
            s_d        = step_ns;
            sys_d      = step_u;
            par_d      = step_par;
            valid_d    = 1'b1;
            tail_d     = 1'b1;
            frame_en_d = 1'b1;
            if (cnt_q == LastTail) begin
               cnt_d   = '0;
               state_d = StFin;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         s_q        <= '0;
         cnt_q      <= '0;
         sys_q      <= 1'b0;
         par_q      <= 1'b0;
         valid_q    <= 1'b0;
         tail_q     <= 1'b0;
         frame_en_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         cnt_q      <= cnt_d;
         sys_q      <= sys_d;
         par_q      <= par_d;
         valid_q    <= valid_d;
         tail_q     <= tail_d;
         frame_en_q <= frame_en_d;
         done_q     <= done_d;
      end
   end

   assign in_ready     = (state_q == StEncode);
   assign sys_out      = sys_q;
   assign par_out      = par_q;
   assign out_valid    = valid_q;
   assign tail_flag    = tail_q;
   assign out_frame_en = frame_en_q;
   assign done         = done_q;

endmodule

// File: doc/rsc_frame_encoder.md
Name: rsc_frame_encoder

Overview:
- Constituent recursive systematic convolutional (RSC) encoder for the turbo encoder path.
- Accepts a serial information frame of FRAME_LEN bits and emits one systematic bit and one parity bit per accepted bit, then optional trellis-termination tail bits.
- The parity stream and out_frame_en drive the downstream serial-to-nibble packer (c2b_in / c2b_en).
- Rate 1/2 per constituent: feedback g0 = 13 octal (1+D^2+D^3), feedforward g1 = 15 octal (1+D+D^3).

Parameters:
- FRAME_LEN, 64, information bits per frame; must be greater than or equal to 4.
- CNT_W, 7, bit-counter width; must hold FRAME_LEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; arms a new frame; honoured only in IDLE.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial information bit.
- in_ready  out  1  high in ENCODE only.
- sys_out  out  1  systematic bit, registered.
- par_out  out  1  parity bit, registered.
- out_valid  out  1  sys_out/par_out valid this cycle.
- tail_flag  out  1  current output is a tail bit.
- out_frame_en  out  1  level; high from the first out_valid of a frame until the next start or rst (downstream enable).
- done  out  1  one-cycle pulse after the last output of a frame.

Behaviour:
- Reset: rst is synchronous, active-high, and takes priority over all other inputs. It forces state to IDLE, shift register s[2:0] to 0, bit counter to 0, and all outputs to 0. Reset mid-frame aborts the frame with no done pulse.
- Trellis step for input u:
  - a = u ^ s1 ^ s2
  - parity = a ^ s0 ^ s2
  - next state: s0<=a, s1<=s0, s2<=s1
- FSM states: IDLE, ENCODE, TAIL, FIN.
- IDLE:
  - start=1 -> ENCODE; clears s, counter and out_frame_en.
  - in_valid is ignored.
- ENCODE:
  - in_ready=1.
  - On each in_valid: one trellis step; sys_out<=in_bit, par_out<=parity, out_valid<=1 on the next cycle (latency 1); counter increments.
  - No in_valid -> out_valid=0; state and counter hold.
  - On the FRAME_LEN-th accepted bit -> TAIL.
- TAIL:
  - Exactly 3 cycles, independent of in_valid.
  - u = s1 ^ s2, so a = 0; sys_out<=u, par_out<=parity, tail_flag<=1, out_valid<=1.
  - s is 0 after the 3rd cycle. Then -> FIN.
- FIN: done=1 for one cycle -> IDLE.
- out_frame_en:
  - Set together with the first out_valid of a frame; held through FIN and IDLE.
  - Cleared by start or rst.
  - The downstream packer counts every clock while enabled, so in_valid must be gap-free for packer alignment; gaps are legal here but stall the outputs.
- start outside IDLE is ignored. in_valid outside ENCODE is ignored (in_ready=0).
- Counter wrap: impossible by construction; the counter clears on start.

Optional Feature:
- Macro: RSC_TAIL_BITS_EN.
- Defined: TAIL state present; 3 termination outputs per frame; final s = 0.
- Undefined: ENCODE -> FIN directly after the FRAME_LEN-th bit; tail_flag tied 0; final state is left unterminated.

Decomposition:
- Shared package turbo_pkg holds:
  - FSM state enum (IDLE/ENCODE/TAIL/FIN).
  - G0_FB = 3'b011 and G1_FF = 3'b101 tap constants (D1..D3 taps).
  - Default FRAME_LEN = 64, shared with the packer.
- Natural sub-module rsc_trellis_step: combinational step taking u and s[2:0] and producing a, parity and next_s. It is reused by the second constituent encoder.

Test Plan:
- All-zero frame of 64 bits, in_valid continuous -> 64 outputs with sys=0, par=0; 3 tail outputs all 0; done 68 cycles after the first accepted bit.
- Impulse (1 then 63 zeros) -> first five par_out 1,1,1,1,0. Parity is periodic with period 7. Tail outputs drive s to 0, checked via a reference model on sys/par.
- Random frame vs. bit-accurate model, with in_valid gaps inserted -> outputs match, out_valid only on accepted bits plus 3 tail cycles, out_frame_en never drops mid-frame.
- start pulsed during ENCODE at bit 10 -> ignored; frame completes normally with 64 outputs.
- rst asserted at bit 30 -> next cycle all outputs 0 and state IDLE, no done. A subsequent start+frame encodes from s=0.
- RSC_TAIL_BITS_EN undefined, all-ones frame -> exactly 64 outputs, tail_flag never 1, done one cycle after the last out_valid.
